slave_in_port: RTL and testbench

Serial receive port on the slave side of the system bus. It consumes the bit-serial stream driven by the master output port: it handshakes on master_valid/slave_ready, then deserialises address and write data LSB-first. It presents a parallel read/write request to the slave core and holds the request until the core completes. The slave output port (read-data return) sits alongside it.

---
 rtl/slave_in_port_pkg.sv | 29 ++
 rtl/serial_shift_in.sv | 44 ++++
 rtl/slave_in_port.sv | 199 +++++++++++++++++++
 tb/tb_slave_in_port.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/slave_in_port_pkg.sv
// ----------------------------------------------------------------------------
// slave_in_port_pkg
// Shared bus definitions for the serial master/slave ports:
//   - receive FSM state encoding (IDLE / RX / WAIT_CORE)
//   - instruction encoding used on the write_en/read_en pair
//   - default address / data line lengths
//   - max_len helper for sizing the per-transfer bit count
// ----------------------------------------------------------------------------
package slave_in_port_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RX        = 2'd1,
        WAIT_CORE = 2'd2
    } rx_state_e;

    // {write_en|read_en, read_en} style encoding shared with the master ports
    localparam logic [1:0] INSTR_INACTIVE = 2'b00;
    localparam logic [1:0] INSTR_WRITE    = 2'b10;
    localparam logic [1:0] INSTR_READ     = 2'b11;

    localparam int DEFAULT_ADDR_LEN = 12;
    localparam int DEFAULT_DATA_LEN = 8;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// ----------------------------------------------------------------------------
// serial_shift_in
// Indexed serial-to-parallel capture register. When en is high the bit at
// position index is loaded from bit_in; every other bit holds. An index at or
// beyond WIDTH loads nothing, so longer transfers simply drop excess bits.
// Ports:
//   clk, reset  : clock, async active-high reset (register clears to 0)
//   en          : capture strobe
//   bit_in      : serial bit
//   index       : bit position to load
//   par_q       : registered parallel value
//   par_d       : next-state value (used for end-of-transfer decisions)
// ----------------------------------------------------------------------------
module serial_shift_in #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             bit_in,
    input  logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] par_q,
    output logic [WIDTH-1:0] par_d
);

    always_comb begin
        par_d = par_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (en && (index == IDX_W'(i))) begin
                par_d[i] = bit_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// ----------------------------------------------------------------------------
// slave_in_port
// Serial receive port on the slave side of the system bus. Handshakes with the
// master (master_valid & slave_ready & exactly one of write_en/read_en), then
// deserialises address and write data LSB-first over N = max(ADDR_LEN,
// DATA_LEN) clock edges and raises mem_write / mem_read on the edge that
// samples the last bit. The request is held until core_done.
//
// Optional feature macro: SLAVE_IN_ADDR_CHECK_EN
//   When defined, a completed transfer whose address is >= MEM_DEPTH is not
//   dispatched; rx_error pulses and the port returns to IDLE instead.
//
// Ports:
//   clk, reset                  : clock (rising), async active-high reset
//   master_valid, write_en,
//   read_en                     : master request/handshake
//   rx_address, rx_data         : serial address / write-data bits, LSB first
//   slave_ready                 : port idle, accepts handshake
//   mem_address, mem_wdata      : deserialised request to the core
//   mem_write, mem_read         : request levels, held until core_done
//   core_done                   : core finished current request
//   rx_error                    : one-cycle pulse on protocol/address error
// ----------------------------------------------------------------------------
module slave_in_port
    import slave_in_port_pkg::*;
#(
    parameter int ADDR_LEN  = DEFAULT_ADDR_LEN,
    parameter int DATA_LEN  = DEFAULT_DATA_LEN,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic [ADDR_LEN-1:0] mem_address,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_write,
    output logic                mem_read,
    input  logic                core_done,
    output logic                rx_error
);

    localparam int N  = max_len(ADDR_LEN, DATA_LEN);
    localparam int CW = $clog2(N) + 1;

    rx_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    mode_q, mode_d;
    logic          slave_ready_q, slave_ready_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_read_q, mem_read_d;
    logic          rx_error_q, rx_error_d;

    logic                addr_en, data_en;
    logic [CW-1:0]       shift_idx;
    logic [ADDR_LEN-1:0] addr_next;
    logic [DATA_LEN-1:0] data_next;
    logic                range_err;

    serial_shift_in #(.WIDTH(ADDR_LEN), .IDX_W(CW)) u_addr_shift (
        .clk    (clk),
        .reset  (reset),
        .en     (addr_en),
        .bit_in (rx_address),
        .index  (shift_idx),
        .par_q  (mem_address),
        .par_d  (addr_next)
    );

    serial_shift_in #(.WIDTH(DATA_LEN), .IDX_W(CW)) u_data_shift (
        .clk    (clk),
        .reset  (reset),
        .en     (data_en),
        .bit_in (rx_data),
        .index  (shift_idx),
        .par_q  (mem_wdata),
        .par_d  (data_next)
    );

    // Range check looks at the address including the bit sampled this edge,
    // so the decision is made without an extra cycle.
`ifdef SLAVE_IN_ADDR_CHECK_EN
    assign range_err = (32'(addr_next) >= 32'(MEM_DEPTH));
    logic unused_data_next;
    assign unused_data_next = ^data_next;
`else
    assign range_err = 1'b0;
    logic unused_cfg;
    assign unused_cfg = (MEM_DEPTH > 0) ^ (^addr_next) ^ (^data_next);
`endif

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        mode_d        = mode_q;
        slave_ready_d = slave_ready_q;
        mem_write_d   = mem_write_q;
        mem_read_d    = mem_read_q;
        rx_error_d    = 1'b0;
        addr_en       = 1'b0;
        data_en       = 1'b0;
        shift_idx     = count_q;

        case (state_q)
            IDLE: begin
                if (master_valid && slave_ready_q) begin
                    if (write_en && read_en) begin
                        rx_error_d = 1'b1;
                    end else if (write_en ^ read_en) begin
                        // Bit 0 is already on the lines at the handshake edge.
                        addr_en       = 1'b1;
                        data_en       = write_en;
                        shift_idx     = '0;
                        mode_d        = write_en ? INSTR_WRITE : INSTR_READ;
                        count_d       = CW'(1);
                        slave_ready_d = 1'b0;
                        state_d       = RX;
                    end
                end
            end

            RX: begin
                if (!master_valid) begin
                    // Abort: partial shift contents are left as they are.
                    rx_error_d    = 1'b1;
                    count_d       = '0;
                    mode_d        = INSTR_INACTIVE;
                    slave_ready_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    addr_en = 1'b1;
                    data_en = (mode_q == INSTR_WRITE);
                    if (count_q == CW'(N - 1)) begin
                        count_d = '0;
                        if (range_err) begin
                            rx_error_d    = 1'b1;
                            mode_d        = INSTR_INACTIVE;
                            slave_ready_d = 1'b1;
                            state_d       = IDLE;
                        end else begin
                            mem_write_d = (mode_q == INSTR_WRITE);
                            mem_read_d  = (mode_q == INSTR_READ);
                            state_d     = WAIT_CORE;
                        end
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end

            WAIT_CORE: begin
                if (core_done) begin
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b0;
                    mode_d        = INSTR_INACTIVE;
                    slave_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d       = IDLE;
                slave_ready_d = 1'b1;
                mem_write_d   = 1'b0;
                mem_read_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            mode_q        <= INSTR_INACTIVE;
            slave_ready_q <= 1'b1;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            rx_error_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            mode_q        <= mode_d;
            slave_ready_q <= slave_ready_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            rx_error_q    <= rx_error_d;
        end
    end

    assign slave_ready = slave_ready_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign rx_error    = rx_error_q;

endmodule

// File: tb/tb_slave_in_port.sv
module tb_slave_in_port;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [11:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        master_valid, write_en, read_en, rx_address, rx_data;
    logic        slave_ready;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_write, mem_read;
    logic        core_done;
    logic        rx_error;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    slave_in_port #(.ADDR_LEN(12), .DATA_LEN(8), .MEM_DEPTH(2048)) dut (
        .clk          (clk),
        .reset        (reset),
        .master_valid (master_valid),
        .write_en     (write_en),
        .read_en      (read_en),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .slave_ready  (slave_ready),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .core_done    (core_done),
        .rx_error     (rx_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [11:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic compare_ev(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d addr 0x%0h data 0x%0h, expected nothing",
                     kind, mem_address, mem_wdata);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind != K_ERR && (e.addr !== mem_address || e.data !== mem_wdata))) begin
                errors++;
                $display("FAIL sb_event: got kind %0d addr 0x%0h data 0x%0h, expected kind %0d addr 0x%0h data 0x%0h",
                         kind, mem_address, mem_wdata, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every new request and every rx_error pulse is matched in order.
    task automatic monitor();
        logic prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (mem_write && mem_read) begin
                    checks++;
                    errors++;
                    $display("FAIL req_exclusive: mem_write=1 mem_read=1 expected at most one");
                end
                if ((mem_write || mem_read) && !prev_req) compare_ev(mem_write ? K_WR : K_RD);
                if (rx_error) compare_ev(K_ERR);
                prev_req = mem_write || mem_read;
            end
        end
    endtask

    // Drive nbits serial bits starting with the handshake edge.
    task automatic send_bits(input logic w, input logic r, input logic [11:0] a,
                             input logic [11:0] d, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            master_valid = 1'b1; write_en = w; read_en = r;
            rx_address = a[i]; rx_data = d[i];
            if (i == 11) check("early_req", {30'd0, mem_write, mem_read}, 32'd0);
            @(posedge clk);
        end
    endtask

    task automatic do_xfer(input logic w, input logic r, input logic [11:0] a,
                           input logic [11:0] d, input logic [7:0] exp_wdata, input bit exp_req);
        if (exp_req) push_ev(w ? K_WR : K_RD, a, exp_wdata);
        else         push_ev(K_ERR, 12'h0, 8'h0);
        send_bits(w, r, a, d, 12);
        @(negedge clk);
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        if (exp_req) begin
            check("req_level", {31'd0, (w ? mem_write : mem_read)}, 32'd1);
            check("ready_busy", {31'd0, slave_ready}, 32'd0);
            @(negedge clk);
            check("req_held", {30'd0, mem_write, mem_read}, w ? 32'd2 : 32'd1);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
            check("ready_after_done", {31'd0, slave_ready}, 32'd1);
            check("req_cleared", {30'd0, mem_write, mem_read}, 32'd0);
        end else begin
            check("ready_after_rangeerr", {31'd0, slave_ready}, 32'd1);
            check("no_req_rangeerr", {30'd0, mem_write, mem_read}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        rx_address = 1'b0; rx_data = 1'b0; core_done = 1'b0;
        fork
            monitor();
        join_none
        #1;
        check("rst_ready", {31'd0, slave_ready}, 32'd1);
        check("rst_addr", {20'd0, mem_address}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_req", {30'd0, mem_write, mem_read}, 32'd0);
        check("rst_err", {31'd0, rx_error}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Write 0xA5C / 0x3B
        do_xfer(1'b1, 1'b0, 12'hA5C, 12'h03B, 8'h3B, 1'b1);

        // Read 0x123 with toggling rx_data: wdata must stay 0x3B
        do_xfer(1'b0, 1'b1, 12'h123, 12'h555, 8'h3B, 1'b1);
        check("read_keeps_wdata", {24'd0, mem_wdata}, 32'h3B);

        // Abort after 5 bits of a write of 0x0F0 / 0x42
        push_ev(K_ERR, 12'h0, 8'h0);
        send_bits(1'b1, 1'b0, 12'h0F0, 12'h042, 5);
        @(negedge clk);
        master_valid = 1'b0; write_en = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, slave_ready}, 32'd1);
        check("abort_no_req", {30'd0, mem_write, mem_read}, 32'd0);
        check("abort_partial_addr", {20'd0, mem_address}, 32'h130);
        check("abort_partial_wdata", {24'd0, mem_wdata}, 32'h22);

        // Illegal write_en & read_en
        push_ev(K_ERR, 12'h0, 8'h0);
        master_valid = 1'b1; write_en = 1'b1; read_en = 1'b1;
        rx_address = 1'b1; rx_data = 1'b1;
        @(negedge clk);
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        check("illegal_ready", {31'd0, slave_ready}, 32'd1);
        check("illegal_addr_kept", {20'd0, mem_address}, 32'h130);
        check("illegal_wdata_kept", {24'd0, mem_wdata}, 32'h22);

        // master_valid with no enable: ignored
        master_valid = 1'b1;
        repeat (2) @(negedge clk);
        master_valid = 1'b0;
        check("noen_ready", {31'd0, slave_ready}, 32'd1);
        check("noen_addr", {20'd0, mem_address}, 32'h130);

        // Reset after 6 bits, then a clean write 0x001 / 0xFF
        send_bits(1'b1, 1'b0, 12'hFFF, 12'h0FF, 6);
        @(negedge clk);
        reset = 1'b1;
        master_valid = 1'b0; write_en = 1'b0;
        #1;
        check("midrst_ready", {31'd0, slave_ready}, 32'd1);
        check("midrst_addr", {20'd0, mem_address}, 32'd0);
        check("midrst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("midrst_req", {30'd0, mem_write, mem_read}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_xfer(1'b1, 1'b0, 12'h001, 12'h0FF, 8'hFF, 1'b1);

`ifdef SLAVE_IN_ADDR_CHECK_EN
        do_xfer(1'b1, 1'b0, 12'h800, 12'h011, 8'h00, 1'b0);
        do_xfer(1'b1, 1'b0, 12'h7FF, 12'h022, 8'h22, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
